// File: rtl/pattern_stream_checker_if.sv
// Read port of the camera debug FIFO as seen by a stream consumer.
// The master side pulls words; the slave side is the FIFO with a registered Q output.
interface pattern_stream_checker_if;
    logic        queue_empty;
    logic [16:0] queue_data;
    logic        queue_rd_en;

    modport master (
        input  queue_empty,
        input  queue_data,
        output queue_rd_en
    );

    modport slave (
        output queue_empty,
        output queue_data,
        input  queue_rd_en
    );
endinterface

// File: rtl/pattern_stream_checker.sv
// Reads the debug pattern stream from the camera FIFO, locks onto the frame-start flag and
// checks every pixel against the colour-bar pattern, reporting frames, mismatches and framing errors.
module pattern_stream_checker #(
    parameter int FRAME_WIDTH    = 640,
    parameter int FRAME_HEIGHT   = 480,
    parameter int NUM_COLOR_BARS = 10
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     enable,
    pattern_stream_checker_if.master q,
    output logic                     frame_done,
    output logic [15:0]              frame_count,
    output logic [15:0]              mismatch_count,
    output logic                     sync_error,
    output logic [10:0]              first_err_col,
    output logic [9:0]               first_err_row,
    output logic                     locked
);

    localparam int          BAR_W    = FRAME_WIDTH / NUM_COLOR_BARS;
    localparam logic [10:0] COL_LAST = 11'(FRAME_WIDTH - 1);
    localparam logic [9:0]  ROW_LAST = 10'(FRAME_HEIGHT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SYNC = 2'd1,
        RUN  = 2'd2
    } state_t;

    function automatic logic [15:0] bar_table(input int idx);
        logic [15:0] clr;
        case (idx)
            0:       clr = 16'hFFFF;
            1:       clr = 16'hFFE0;
            2:       clr = 16'h07FF;
            3:       clr = 16'h07E0;
            4:       clr = 16'hF81F;
            5:       clr = 16'hF800;
            6:       clr = 16'h001F;
            7:       clr = 16'h0000;
            8:       clr = 16'h8410;
            9:       clr = 16'hFD20;
            default: clr = 16'h0000;
        endcase
        return clr;
    endfunction

    // Walking down from the last bar lets the smallest matching bar win without a divider.
    function automatic logic [15:0] expected_color(input logic [10:0] col);
        logic [15:0] clr;
        clr = 16'h0000;
        for (int i = NUM_COLOR_BARS - 1; i >= 0; i--) begin
            if (32'(col) < 32'((i + 1) * BAR_W)) begin
                clr = bar_table(i);
            end
        end
        return clr;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    state_t      state_q, state_d;
    logic [10:0] col_q, col_d;
    logic [9:0]  row_q, row_d;
    logic        rd_valid_q;
    logic        frame_done_q, frame_done_d;
    logic [15:0] frame_count_q, frame_count_d;
    logic [15:0] mismatch_q, mismatch_d;
    logic        sync_error_q, sync_error_d;
    logic [10:0] err_col_q, err_col_d;
    logic [9:0]  err_row_q, err_row_d;

    logic        flag;
    logic        at_start;
    logic        chk;
    logic [10:0] chk_col;
    logic [9:0]  chk_row;

    assign flag     = q.queue_data[16];
    assign at_start = (col_q == 11'd0) && (row_q == 10'd0);

    assign q.queue_rd_en = enable & ~q.queue_empty & (state_q != IDLE);

    // Stage 0 -> 1: FIFO Q is registered, so the word read now is valid next cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= q.queue_rd_en;
        end
    end

    always_comb begin
        state_d       = state_q;
        col_d         = col_q;
        row_d         = row_q;
        frame_done_d  = 1'b0;
        frame_count_d = frame_count_q;
        mismatch_d    = mismatch_q;
        sync_error_d  = sync_error_q;
        err_col_d     = err_col_q;
        err_row_d     = err_row_q;
        chk           = 1'b0;
        chk_col       = col_q;
        chk_row       = row_q;

        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d = SYNC;
                end
            end
            SYNC: begin
                if (rd_valid_q && flag) begin
                    chk     = 1'b1;
                    chk_col = 11'd0;
                    chk_row = 10'd0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (rd_valid_q) begin
                    if (flag && !at_start) begin
                        // Early frame start: resynchronise on this word and keep checking.
                        sync_error_d = 1'b1;
                        chk          = 1'b1;
                        chk_col      = 11'd0;
                        chk_row      = 10'd0;
                    end else if (!flag && at_start) begin
                        sync_error_d = 1'b1;
                        state_d      = SYNC;
                    end else begin
                        chk = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (chk) begin
            if (q.queue_data[15:0] != expected_color(chk_col)) begin
                mismatch_d = sat_inc16(mismatch_q);
                // Counter saturates rather than wraps, so zero means no mismatch seen yet.
                if (mismatch_q == 16'd0) begin
                    err_col_d = chk_col;
                    err_row_d = chk_row;
                end
            end
            if (chk_col == COL_LAST) begin
                col_d = 11'd0;
                if (chk_row == ROW_LAST) begin
                    row_d         = 10'd0;
                    frame_done_d  = 1'b1;
                    frame_count_d = frame_count_q + 16'd1;
                end else begin
                    row_d = chk_row + 10'd1;
                end
            end else begin
                col_d = chk_col + 11'd1;
                row_d = chk_row;
            end
        end
    end

    // Stage 1 -> 2: check results and position become visible.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            col_q         <= 11'd0;
            row_q         <= 10'd0;
            frame_done_q  <= 1'b0;
            frame_count_q <= 16'd0;
            mismatch_q    <= 16'd0;
            sync_error_q  <= 1'b0;
            err_col_q     <= 11'd0;
            err_row_q     <= 10'd0;
        end else begin
            state_q       <= state_d;
            col_q         <= col_d;
            row_q         <= row_d;
            frame_done_q  <= frame_done_d;
            frame_count_q <= frame_count_d;
            mismatch_q    <= mismatch_d;
            sync_error_q  <= sync_error_d;
            err_col_q     <= err_col_d;
            err_row_q     <= err_row_d;
        end
    end

    assign frame_done     = frame_done_q;
    assign frame_count    = frame_count_q;
    assign mismatch_count = mismatch_q;
    assign sync_error     = sync_error_q;
    assign first_err_col  = err_col_q;
    assign first_err_row  = err_row_q;
    assign locked         = (state_q == RUN);

endmodule

// File: tb/tb_pattern_stream_checker.sv
// Bench for pattern_stream_checker: a FIFO model with registered Q feeds directed frames while a
// reference model predicts the outputs of every word read; predictions are queued and compared two cycles later.
module tb_pattern_stream_checker;

    localparam int W     = 640;
    localparam int H     = 20;
    localparam int BAR_W = W / 10;
    localparam int FRAME = W * H;

    logic        clk;
    logic        reset_n;
    logic        enable;
    logic        frame_done;
    logic [15:0] frame_count;
    logic [15:0] mismatch_count;
    logic        sync_error;
    logic [10:0] first_err_col;
    logic [9:0]  first_err_row;
    logic        locked;

    pattern_stream_checker_if qif ();

    pattern_stream_checker #(
        .FRAME_WIDTH   (W),
        .FRAME_HEIGHT  (H),
        .NUM_COLOR_BARS(10)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .enable        (enable),
        .q             (qif),
        .frame_done    (frame_done),
        .frame_count   (frame_count),
        .mismatch_count(mismatch_count),
        .sync_error    (sync_error),
        .first_err_col (first_err_col),
        .first_err_row (first_err_row),
        .locked        (locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // FIFO model: the stimulus process writes, this block reads with a registered output.
    logic [16:0] mem [65536];
    int unsigned wr_cnt;
    int unsigned rd_cnt;

    initial rd_cnt = 0;
    assign qif.queue_empty = (wr_cnt == rd_cnt);

    always @(posedge clk) begin
        if (qif.queue_rd_en) begin
            qif.queue_data <= mem[rd_cnt[15:0]];
            rd_cnt         <= rd_cnt + 1;
        end
    end

    typedef struct packed {
        logic        fd;
        logic [15:0] fc;
        logic [15:0] mc;
        logic        se;
        logic [10:0] fec;
        logic [9:0]  fer;
        logic        lk;
    } rec_t;

    rec_t sb_q[$];
    rec_t p_rec;
    logic p_vld;
    int   checks;
    int   failures;

    int          m_run;
    int          m_col;
    int          m_row;
    logic [15:0] m_fc;
    logic [15:0] m_mc;
    logic        m_se;
    logic        m_has_err;
    logic [10:0] m_fec;
    logic [9:0]  m_fer;

    function automatic logic [15:0] tb_color(input int c);
        int b;
        b = c / BAR_W;
        case (b)
            0: return 16'hFFFF;
            1: return 16'hFFE0;
            2: return 16'h07FF;
            3: return 16'h07E0;
            4: return 16'hF81F;
            5: return 16'hF800;
            6: return 16'h001F;
            7: return 16'h0000;
            8: return 16'h8410;
            9: return 16'hFD20;
            default: return 16'h0000;
        endcase
    endfunction

    function automatic logic [16:0] pat_word(input int idx);
        return {(idx == 0), tb_color(idx % W)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_run = 0; m_col = 0; m_row = 0;
        m_fc = '0; m_mc = '0; m_se = 1'b0; m_has_err = 1'b0;
        m_fec = '0; m_fer = '0;
    endtask

    task automatic model_word(input logic [16:0] w, output rec_t r);
        logic do_chk;
        int   cc;
        int   rr;
        do_chk = 1'b0;
        cc     = m_col;
        rr     = m_row;
        r.fd   = 1'b0;
        if (m_run == 0) begin
            if (w[16]) begin m_run = 1; do_chk = 1'b1; cc = 0; rr = 0; end
        end else if (w[16] && (m_col != 0 || m_row != 0)) begin
            m_se = 1'b1; do_chk = 1'b1; cc = 0; rr = 0;
        end else if (!w[16] && m_col == 0 && m_row == 0) begin
            m_se = 1'b1; m_run = 0;
        end else begin
            do_chk = 1'b1;
        end
        if (do_chk) begin
            if (w[15:0] != tb_color(cc)) begin
                if (m_mc != 16'hFFFF) m_mc = m_mc + 16'd1;
                if (!m_has_err) begin m_has_err = 1'b1; m_fec = 11'(cc); m_fer = 10'(rr); end
            end
            cc++;
            if (cc == W) begin
                cc = 0; rr++;
                if (rr == H) begin rr = 0; r.fd = 1'b1; m_fc = m_fc + 16'd1; end
            end
            m_col = cc; m_row = rr;
        end
        r.fc = m_fc; r.mc = m_mc; r.se = m_se; r.fec = m_fec; r.fer = m_fer; r.lk = (m_run != 0);
    endtask

    task automatic push(input logic [16:0] w);
        rec_t r;
        model_word(w, r);
        sb_q.push_back(r);
        mem[wr_cnt[15:0]] = w;
        wr_cnt++;
    endtask

    // One clock: sample the read decision for the coming edge, then compare the word read two edges back.
    task automatic tick();
        logic rd;
        rec_t r;
        r = '0;
        #1;
        rd = qif.queue_rd_en;
        if (qif.queue_empty) chk("no_read_when_empty", 32'(rd), 32'd0);
        if (!enable) chk("no_read_when_disabled", 32'(rd), 32'd0);
        if (rd) begin
            chk("scoreboard_nonempty", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) r = sb_q.pop_front();
            else rd = 1'b0;
        end
        @(negedge clk);
        if (p_vld) begin
            chk("frame_done", 32'(frame_done), 32'(p_rec.fd));
            chk("frame_count", 32'(frame_count), 32'(p_rec.fc));
            chk("mismatch_count", 32'(mismatch_count), 32'(p_rec.mc));
            chk("sync_error", 32'(sync_error), 32'(p_rec.se));
            chk("first_err_col", 32'(first_err_col), 32'(p_rec.fec));
            chk("first_err_row", 32'(first_err_row), 32'(p_rec.fer));
            chk("locked", 32'(locked), 32'(p_rec.lk));
        end else begin
            chk("frame_done_idle", 32'(frame_done), 32'd0);
        end
        p_vld = rd;
        p_rec = r;
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int n;
        n = 0;
        while (!(wr_cnt == rd_cnt && sb_q.size() == 0 && !p_vld) && n < budget) begin
            tick();
            n++;
        end
        chk({"drain_", tag}, 32'(wr_cnt == rd_cnt && sb_q.size() == 0 && !p_vld), 32'd1);
    endtask

    task automatic check_cleared(input string tag);
        chk({tag, "_frame_done"}, 32'(frame_done), 32'd0);
        chk({tag, "_frame_count"}, 32'(frame_count), 32'd0);
        chk({tag, "_mismatch"}, 32'(mismatch_count), 32'd0);
        chk({tag, "_sync_error"}, 32'(sync_error), 32'd0);
        chk({tag, "_err_col"}, 32'(first_err_col), 32'd0);
        chk({tag, "_err_row"}, 32'(first_err_row), 32'd0);
        chk({tag, "_locked"}, 32'(locked), 32'd0);
        chk({tag, "_rd_en"}, 32'(qif.queue_rd_en), 32'd0);
    endtask

    initial begin
        logic [16:0] w;
        int          n;
        int unsigned base;
        checks   = 0;
        failures = 0;
        wr_cnt   = 0;
        p_vld    = 1'b0;
        p_rec    = '0;
        reset_n  = 1'b1;
        enable   = 1'b0;
        model_reset();

        tick();
        reset_n = 1'b0;
        repeat (3) tick();
        check_cleared("reset");
        reset_n = 1'b1;

        // Three unflagged words ahead of a clean frame; nothing is read while still idle.
        for (int i = 0; i < 3; i++) push({1'b0, 16'($urandom)});
        for (int k = 0; k < FRAME; k++) push(pat_word(k));
        repeat (4) tick();
        chk("idle_no_lock", 32'(locked), 32'd0);
        chk("idle_nothing_read", rd_cnt, 32'd0);
        enable = 1'b1;
        wait_drain("frame_a", 20000);
        chk("a_frame_count", 32'(frame_count), 32'd1);
        chk("a_mismatch", 32'(mismatch_count), 32'd0);
        chk("a_sync_error", 32'(sync_error), 32'd0);
        chk("a_locked", 32'(locked), 32'd1);

        // Frame with empty gaps, an enable drop mid-row and one corrupted pixel.
        for (int k = 0; k < FRAME; k++) begin
            if (k > 0 && k % 128 == 0) begin
                wait_drain("gap", 400);
                repeat ($urandom_range(1, 50)) tick();
            end
            if (k == 1000) begin
                repeat (5) tick();
                enable = 1'b0;
                repeat (20) tick();
                chk("disabled_no_error", 32'(sync_error), 32'd0);
                enable = 1'b1;
            end
            w = pat_word(k);
            if (k == 3 * W + 100) w[15:0] = 16'h1234;
            push(w);
        end
        wait_drain("frame_b", 20000);
        chk("b_frame_count", 32'(frame_count), 32'd2);
        chk("b_mismatch", 32'(mismatch_count), 32'd1);
        chk("b_err_col", 32'(first_err_col), 32'd100);
        chk("b_err_row", 32'(first_err_row), 32'd3);
        chk("b_sync_error", 32'(sync_error), 32'd0);

        // Frame start flag forced on pixel (5,2): restart, then a full frame must follow.
        for (int k = 0; k < 2 * W + 5; k++) push(pat_word(k));
        push({1'b1, tb_color(5)});
        for (int k = 1; k < FRAME; k++) push(pat_word(k));
        wait_drain("frame_c", 20000);
        chk("c_sync_error", 32'(sync_error), 32'd1);
        chk("c_frame_count", 32'(frame_count), 32'd3);
        chk("c_mismatch", 32'(mismatch_count), 32'd1);

        // Reset mid-frame, then relock on the next flagged word.
        base = rd_cnt;
        for (int k = 0; k < 500; k++) push(pat_word(k));
        n = 0;
        while (rd_cnt < base + 200 && n < 1000) begin tick(); n++; end
        chk("midframe_progress", 32'(rd_cnt >= base + 200), 32'd1);
        reset_n = 1'b0;
        p_vld   = 1'b0;
        sb_q.delete();
        wr_cnt  = rd_cnt;
        model_reset();
        repeat (2) tick();
        check_cleared("midreset");
        reset_n = 1'b1;
        push({1'b0, 16'h0F0F});
        push({1'b0, 16'hFFFF});
        for (int k = 0; k < 11; k++) push(pat_word(k));
        wait_drain("relock", 200);
        chk("relock_locked", 32'(locked), 32'd1);
        chk("relock_sync_error", 32'(sync_error), 32'd0);
        chk("relock_mismatch", 32'(mismatch_count), 32'd0);

        // Complete the frame, then an unflagged first word drops the lock.
        for (int k = 11; k < FRAME; k++) push(pat_word(k));
        wait_drain("frame_f", 20000);
        chk("f_frame_count", 32'(frame_count), 32'd1);
        chk("f_sync_error", 32'(sync_error), 32'd0);
        push({1'b0, 16'hFFFF});
        wait_drain("bad_start", 50);
        chk("bad_start_sync_error", 32'(sync_error), 32'd1);
        chk("bad_start_unlocked", 32'(locked), 32'd0);
        push({1'b1, 16'hFFFF});
        wait_drain("resync", 50);
        chk("resync_locked", 32'(locked), 32'd1);
        chk("resync_mismatch", 32'(mismatch_count), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
